// File: rtl/uart_transceiver_pkg.sv
// uart_transceiver_pkg: shared FSM state type, bit index type and bit-period helper
package uart_transceiver_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    typedef logic [3:0] bit_idx_t;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_transceiver_if.sv
// uart_transceiver_if: byte-wide ready/valid transmit and receive channels
interface uart_transceiver_if;

    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );

endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver with mid-bit sampling and a ready/valid byte output
module uart_receiver
    import uart_transceiver_pkg::*;
#(
    parameter int SYMBOL_EDGE_TIME = 1085
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready
);

    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] LAST      = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(SYMBOL_EDGE_TIME / 2 - 1);

    state_t     state;
    logic [CW-1:0] cnt;
    bit_idx_t   idx;
    logic [7:0] shreg;
    logic       s1, rx, armed;
    logic       bit_end, half_end;

    assign bit_end  = cnt == LAST;
    assign half_end = cnt == HALF_LAST;

    // Synchronize the line, then hunt for a start bit only after the line has been seen high
    always_ff @(posedge clk) begin
        if (reset) begin
            s1             <= 1'b1;
            rx             <= 1'b1;
            armed          <= 1'b0;
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            s1  <= serial_in;
            rx  <= s1;
            cnt <= (state == IDLE || bit_end || (state == START && half_end)) ? '0 : cnt + 1'b1;
            if (data_out_valid && data_out_ready)
                data_out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    armed <= armed | rx;
                    state <= (armed && !rx) ? START : IDLE;
                end
                START: if (half_end) begin
                    idx   <= '0;
                    state <= rx ? IDLE : DATA;
                end
                DATA: if (bit_end) begin
                    shreg <= {rx, shreg[7:1]};
                    idx   <= idx + 1'b1;
                    state <= (idx == 4'd7) ? STOP : DATA;
                end
                STOP: if (bit_end) begin
                    data_out       <= rx ? shreg : data_out;
                    data_out_valid <= rx | data_out_valid;
                    armed          <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 parallel-to-serial transmitter with a ready/valid byte input
module uart_transmitter
    import uart_transceiver_pkg::*;
#(
    parameter int SYMBOL_EDGE_TIME = 1085
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] LAST = CW'(SYMBOL_EDGE_TIME - 1);

    state_t     state;
    logic [CW-1:0] cnt;
    bit_idx_t   idx;
    logic [7:0] shreg;
    logic       bit_end;

    assign bit_end = cnt == LAST;

    // Frame sequencer: start bit, eight data bits LSB first from a private copy, stop bit
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            serial_out    <= 1'b1;
            data_in_ready <= 1'b0;
        end else begin
            cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    data_in_ready <= !(data_in_valid && data_in_ready);
                    if (data_in_valid && data_in_ready) begin
                        shreg      <= data_in;
                        serial_out <= 1'b0;
                        state      <= START;
                    end
                end
                START: if (bit_end) begin
                    serial_out <= shreg[0];
                    idx        <= '0;
                    state      <= DATA;
                end
                DATA: if (bit_end) begin
                    shreg      <= shreg >> 1;
                    serial_out <= (idx == 4'd7) ? 1'b1 : shreg[1];
                    idx        <= idx + 1'b1;
                    state      <= (idx == 4'd7) ? STOP : DATA;
                end
                STOP: if (bit_end) begin
                    data_in_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART wiring an independent transmitter and receiver
module uart_transceiver
    import uart_transceiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic               clk,
    input  logic               reset,
    uart_transceiver_if.slave  bus,
    output logic               serial_out,
    input  logic               serial_in
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);

    uart_transmitter #(.SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)) u_tx (
        .clk           (clk),
        .reset         (reset),
        .data_in       (bus.data_in),
        .data_in_valid (bus.data_in_valid),
        .data_in_ready (bus.data_in_ready),
        .serial_out    (serial_out)
    );

    uart_receiver #(.SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)) u_rx (
        .clk            (clk),
        .reset          (reset),
        .serial_in      (serial_in),
        .data_out       (bus.data_out),
        .data_out_valid (bus.data_out_valid),
        .data_out_ready (bus.data_out_ready)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: scenario tasks checking the UART against a frame-level reference model
module tb_uart_transceiver;

    localparam int CLOCK_FREQ = 50_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int SET        = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF       = SET / 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic loop = 1'b0;
    logic line = 1'b1;
    logic serial_out;
    logic serial_in;
    int checks = 0;
    int passed = 0;

    uart_transceiver_if bus();

    assign serial_in = loop ? serial_out : line;

    uart_transceiver #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .serial_out (serial_out),
        .serial_in  (serial_in)
    );

    always #5 clk = ~clk;

    initial begin
        #(95_000 * 10);
        $display("FAIL watchdog: simulation did not finish within 95000 cycles");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 * SET && !ok; i++) begin
            @(negedge clk);
            ok = bus.data_in_ready;
        end
        if (ok) begin
            bus.data_in       = b;
            bus.data_in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.data_in_valid = 1'b0;
            bus.data_in       = 8'($urandom);
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            line = f[k];
            repeat (SET - 1) @(negedge clk);
        end
        @(negedge clk);
        line = 1'b1;
    endtask

    task automatic consume();
        bus.data_out_ready = 1'b1;
        @(negedge clk);
        bus.data_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (bus.data_in_ready !== 1'b0) $display("FAIL rst_ready_during got=%b exp=0", bus.data_in_ready); else passed++;
        checks++; if (serial_out !== 1'b1) $display("FAIL rst_serial_out got=%b exp=1", serial_out); else passed++;
        checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bus.data_out_valid); else passed++;
        checks++; if (bus.data_out !== 8'h00) $display("FAIL rst_data_out got=%h exp=00", bus.data_out); else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.data_in_ready !== 1'b1) $display("FAIL rst_ready_after got=%b exp=1", bus.data_in_ready); else passed++;
        checks++; if (serial_out !== 1'b1) $display("FAIL rst_serial_after got=%b exp=1", serial_out); else passed++;
        checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL rst_valid_after got=%b exp=0", bus.data_out_valid); else passed++;
    endtask

    task automatic test_tx_waveform();
        logic [7:0] bytes [3];
        logic [9:0] frame;
        bit ok;
        bit hi_seen;
        int low;
        bytes = '{8'h7A, 8'($urandom), 8'($urandom)};
        loop = 1'b0;
        line = 1'b1;
        foreach (bytes[n]) begin
            send_byte(bytes[n], ok);
            checks++; if (!ok) $display("FAIL tx_accept byte=%h got=timeout exp=ready", bytes[n]); else passed++;
            frame = {1'b1, bytes[n], 1'b0};
            low = 0;
            hi_seen = 1'b0;
            for (int j = 0; j < 10 * SET + 2 && !hi_seen; j++) begin
                @(negedge clk);
                if (j < 10 * SET && (j % SET == 0 || j % SET == SET - 1)) begin
                    checks++;
                    if (serial_out !== frame[j / SET])
                        $display("FAIL tx_bit byte=%h bit=%0d cycle=%0d got=%b exp=%b", bytes[n], j / SET, j, serial_out, frame[j / SET]);
                    else passed++;
                end
                if (bus.data_in_ready) hi_seen = 1'b1;
                else low++;
            end
            checks++; if (!hi_seen || low != 10 * SET) $display("FAIL tx_busy_len byte=%h got=%0d exp=%0d", bytes[n], low, 10 * SET); else passed++;
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        bit ok;
        bit got;
        int lat;
        bytes = '{8'h7A, 8'($urandom), 8'($urandom)};
        loop = 1'b1;
        foreach (bytes[n]) begin
            send_byte(bytes[n], ok);
            got = 1'b0;
            lat = 0;
            for (int j = 0; j < 11 * SET && ok && !got; j++) begin
                @(negedge clk);
                if (bus.data_out_valid) begin got = 1'b1; lat = j; end
            end
            checks++;
            if (!got || lat < 9 * SET || lat > 10 * SET)
                $display("FAIL lb_latency byte=%h got=%0d (valid=%b) exp=%0d..%0d", bytes[n], lat, got, 9 * SET, 10 * SET);
            else passed++;
            checks++; if (bus.data_out !== bytes[n]) $display("FAIL lb_data got=%h exp=%h", bus.data_out, bytes[n]); else passed++;
            consume();
            checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL lb_consume got=%b exp=0", bus.data_out_valid); else passed++;
            checks++; if (bus.data_out !== bytes[n]) $display("FAIL lb_hold got=%h exp=%h", bus.data_out, bytes[n]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pay [2];
        int t [2];
        int hs;
        int rxn;
        pay = '{8'h55, 8'hA3};
        t = '{0, 0};
        hs = 0;
        rxn = 0;
        loop = 1'b1;
        for (int j = 0; j < 25 * SET && rxn < 2; j++) begin
            @(negedge clk);
            bus.data_out_ready = 1'b0;
            if (bus.data_out_valid) begin
                checks++; if (bus.data_out !== pay[rxn]) $display("FAIL b2b_rx n=%0d got=%h exp=%h", rxn, bus.data_out, pay[rxn]); else passed++;
                rxn++;
                bus.data_out_ready = 1'b1;
            end
            if (bus.data_in_ready && hs < 2) begin
                bus.data_in       = pay[hs];
                bus.data_in_valid = 1'b1;
                t[hs] = j;
                hs++;
                @(posedge clk);
                #1;
                if (hs == 1) bus.data_in = pay[1];
                else bus.data_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.data_out_ready = 1'b0;
        bus.data_in_valid  = 1'b0;
        checks++; if (rxn != 2) $display("FAIL b2b_count got=%0d exp=2", rxn); else passed++;
        checks++;
        if (hs != 2 || t[1] - t[0] < 10 * SET || t[1] - t[0] > 10 * SET + 1)
            $display("FAIL b2b_gap got=%0d exp=%0d..%0d", t[1] - t[0], 10 * SET, 10 * SET + 1);
        else passed++;
        checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", bus.data_out_valid); else passed++;
    endtask

    task automatic test_overrun_errors();
        logic [7:0] last;
        logic [7:0] rb;
        tick(SET);
        loop = 1'b0;
        line = 1'b1;
        tick(SET);
        drive_frame(8'h11, 1'b1);
        tick(SET);
        drive_frame(8'h22, 1'b1);
        last = 8'h22;
        tick(4);
        checks++; if (bus.data_out !== last) $display("FAIL ovr_data got=%h exp=%h", bus.data_out, last); else passed++;
        checks++; if (bus.data_out_valid !== 1'b1) $display("FAIL ovr_valid got=%b exp=1", bus.data_out_valid); else passed++;
        consume();
        drive_frame(8'($urandom), 1'b0);
        tick(2 * SET);
        checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL frame_err_valid got=%b exp=0", bus.data_out_valid); else passed++;
        checks++; if (bus.data_out !== last) $display("FAIL frame_err_data got=%h exp=%h", bus.data_out, last); else passed++;
        @(negedge clk);
        line = 1'b0;
        repeat (100) @(negedge clk);
        line = 1'b1;
        tick(2 * SET);
        checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL glitch_valid got=%b exp=0", bus.data_out_valid); else passed++;
        checks++; if (bus.data_out !== last) $display("FAIL glitch_data got=%h exp=%h", bus.data_out, last); else passed++;
        repeat (2) begin
            rb = 8'($urandom);
            drive_frame(rb, 1'b1);
            last = rb;
            tick(4);
            checks++; if (bus.data_out_valid !== 1'b1) $display("FAIL rx_rand_valid got=%b exp=1", bus.data_out_valid); else passed++;
            checks++; if (bus.data_out !== last) $display("FAIL rx_rand_data got=%h exp=%h", bus.data_out, last); else passed++;
            consume();
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        bit ok;
        loop = 1'b1;
        b = 8'($urandom) & 8'hF7;
        send_byte(b, ok);
        checks++; if (!ok) $display("FAIL rstmid_accept got=timeout exp=ready"); else passed++;
        repeat (4 * SET + HALF + 1) @(negedge clk);
        checks++; if (serial_out !== 1'b0) $display("FAIL rstmid_bit3 got=%b exp=0", serial_out); else passed++;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (serial_out !== 1'b1) $display("FAIL rstmid_serial got=%b exp=1", serial_out); else passed++;
        checks++; if (bus.data_in_ready !== 1'b0) $display("FAIL rstmid_ready got=%b exp=0", bus.data_in_ready); else passed++;
        tick(3);
        reset = 1'b0;
        tick(12 * SET);
        checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", bus.data_out_valid); else passed++;
        checks++; if (bus.data_out !== 8'h00) $display("FAIL rstmid_data got=%h exp=00", bus.data_out); else passed++;
        checks++; if (bus.data_in_ready !== 1'b1) $display("FAIL rstmid_ready_after got=%b exp=1", bus.data_in_ready); else passed++;
        checks++; if (serial_out !== 1'b1) $display("FAIL rstmid_idle_line got=%b exp=1", serial_out); else passed++;
    endtask

    initial begin
        bus.data_in        = 8'h00;
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 1'b0;
        test_reset();
        test_tx_waveform();
        test_loopback();
        test_back_to_back();
        test_overrun_errors();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
